// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller.
// A CPU-side valid/ready request is latched on the accept edge. The FSM
// launches it on the following edge, then runs a read window or a
// setup/pulse/hold write sequence. Every SRAM-side output is a flop, so the
// SRAM pins do not glitch. The data bus is driven only during the write
// phases and is released again before any later read.

module sram_ctrl #(
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,

    // CPU side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [19:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,

    // SRAM side
    inout  wire  [31:0] ram_data,
    output logic [19:0] ram_addr,
    output logic [3:0]  ram_be_n,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    // Terminal counts of the read window and the write pulse
    localparam logic [3:0] RD_LAST = 4'(READ_CYCLES - 1);
    localparam logic [3:0] WR_LAST = 4'(WRITE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4
    } state_t;

    // FSM state and phase counter
    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;

    // Request latched on the accept edge; pend_reg marks it awaiting launch
    logic        pend_reg, pend_next;
    logic        lat_we_reg, lat_we_next;
    logic [19:0] lat_addr_reg, lat_addr_next;
    logic [3:0]  lat_be_reg, lat_be_next;
    logic [31:0] lat_wdata_reg, lat_wdata_next;

    // Registered SRAM strobes, address, byte enables and bus drive enable
    logic [19:0] ram_addr_reg, ram_addr_next;
    logic [3:0]  ram_be_n_reg, ram_be_n_next;
    logic        ram_ce_n_reg, ram_ce_n_next;
    logic        ram_oe_n_reg, ram_oe_n_next;
    logic        ram_we_n_reg, ram_we_n_next;
    logic        drive_reg, drive_next;

    // Registered CPU-side handshake and response
    logic        req_ready_reg, req_ready_next;
    logic        resp_valid_reg, resp_valid_next;
    logic [31:0] resp_rdata_reg, resp_rdata_next;

    // Next-state, next-output and request-latch logic
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        pend_next       = pend_reg;
        lat_we_next     = lat_we_reg;
        lat_addr_next   = lat_addr_reg;
        lat_be_next     = lat_be_reg;
        lat_wdata_next  = lat_wdata_reg;
        ram_addr_next   = ram_addr_reg;
        ram_be_n_next   = ram_be_n_reg;
        ram_ce_n_next   = ram_ce_n_reg;
        ram_oe_n_next   = ram_oe_n_reg;
        ram_we_n_next   = ram_we_n_reg;
        drive_next      = drive_reg;
        req_ready_next  = req_ready_reg;
        resp_valid_next = 1'b0;
        resp_rdata_next = resp_rdata_reg;

        unique case (state_reg)
            IDLE: begin
                if (pend_reg) begin
                    // Launch the latched request: address, enables and chip
                    // enable all change together on this edge.
                    pend_next      = 1'b0;
                    cnt_next       = 4'd0;
                    ram_addr_next  = lat_addr_reg;
                    ram_ce_n_next  = 1'b0;
                    ram_we_n_next  = 1'b1;
                    req_ready_next = 1'b0;
                    if (lat_we_reg) begin
                        state_next    = WR_SETUP;
                        ram_be_n_next = ~lat_be_reg;
                        ram_oe_n_next = 1'b1;
                        drive_next    = 1'b1;
                    end else begin
                        state_next    = RD;
                        ram_be_n_next = 4'b0000;
                        ram_oe_n_next = 1'b0;
                        drive_next    = 1'b0;
                    end
                end else if (req_valid && req_ready_reg) begin
                    // Accept edge: capture the request and drop ready.
                    pend_next      = 1'b1;
                    lat_we_next    = req_we;
                    lat_addr_next  = req_addr;
                    lat_be_next    = req_be;
                    lat_wdata_next = req_wdata;
                    req_ready_next = 1'b0;
                end else begin
                    req_ready_next = 1'b1;
                end
            end

            RD: begin
                if (cnt_reg == RD_LAST) begin
                    // Sample the bus while oe_n is still low.
                    resp_rdata_next = ram_data;
                    resp_valid_next = 1'b1;
                    ram_ce_n_next   = 1'b1;
                    ram_oe_n_next   = 1'b1;
                    req_ready_next  = 1'b1;
                    state_next      = IDLE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            WR_SETUP: begin
                ram_we_n_next = 1'b0;
                cnt_next      = 4'd0;
                state_next    = WR_PULSE;
            end

            WR_PULSE: begin
                if (cnt_reg == WR_LAST) begin
                    ram_we_n_next = 1'b1;
                    state_next    = WR_HOLD;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            WR_HOLD: begin
                // Data has been held for one cycle past the rising edge of
                // we_n. Release the bus and complete the write.
                ram_ce_n_next   = 1'b1;
                drive_next      = 1'b0;
                resp_valid_next = 1'b1;
                req_ready_next  = 1'b1;
                state_next      = IDLE;
            end

            default: begin
                ram_ce_n_next = 1'b1;
                ram_oe_n_next = 1'b1;
                ram_we_n_next = 1'b1;
                drive_next    = 1'b0;
                state_next    = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            pend_reg       <= 1'b0;
            lat_we_reg     <= 1'b0;
            lat_addr_reg   <= 20'd0;
            lat_be_reg     <= 4'd0;
            lat_wdata_reg  <= 32'd0;
            ram_addr_reg   <= 20'd0;
            ram_be_n_reg   <= 4'b1111;
            ram_ce_n_reg   <= 1'b1;
            ram_oe_n_reg   <= 1'b1;
            ram_we_n_reg   <= 1'b1;
            drive_reg      <= 1'b0;
            req_ready_reg  <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= 32'd0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            pend_reg       <= pend_next;
            lat_we_reg     <= lat_we_next;
            lat_addr_reg   <= lat_addr_next;
            lat_be_reg     <= lat_be_next;
            lat_wdata_reg  <= lat_wdata_next;
            ram_addr_reg   <= ram_addr_next;
            ram_be_n_reg   <= ram_be_n_next;
            ram_ce_n_reg   <= ram_ce_n_next;
            ram_oe_n_reg   <= ram_oe_n_next;
            ram_we_n_reg   <= ram_we_n_next;
            drive_reg      <= drive_next;
            req_ready_reg  <= req_ready_next;
            resp_valid_reg <= resp_valid_next;
            resp_rdata_reg <= resp_rdata_next;
        end
    end

    // Per-byte tristate drivers. The write data is latched only while the
    // bus is released, so the value stays stable whenever it is driven.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign ram_data[8*gi +: 8] = drive_reg ? lat_wdata_reg[8*gi +: 8] : 8'hzz;
        end
    endgenerate

    assign ram_addr   = ram_addr_reg;
    assign ram_be_n   = ram_be_n_reg;
    assign ram_ce_n   = ram_ce_n_reg;
    assign ram_oe_n   = ram_oe_n_reg;
    assign ram_we_n   = ram_we_n_reg;
    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;

endmodule
